// File: rtl/spi_mem_pkg.sv
// Shared types and helpers for the SPI-slave burst RAM.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RW,
        ST_WR_DATA,
        ST_WR_COMMIT,
        ST_RD_LOAD,
        ST_RD_SHIFT,
        ST_HOLD
    } spi_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Width of a counter that runs 0 .. n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_memory_burst_input_conditioner.sv
// Pin synchroniser with one-cycle rise/fall pulses taken from the last two flops.
module spi_input_conditioner #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    // sync_q[0] is the newest sample; SYNC_STAGES must be at least 2.
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  =  sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign fall  = ~sync_q[SYNC_STAGES-2] &  sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave RAM with parametrised address/data width.
// Define SPI_MEM_BURST_EN for auto-incrementing bursts; otherwise one word per frame.
module spi_memory_burst #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic [3:0] leds
);

    import spi_mem_pkg::*;

    localparam int CNT_W = cnt_w((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .pin(sclk_pin),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    // cs idles high so a reset never looks like the start of a frame.
    spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .pin(cs_pin),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .pin(mosi_pin),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_lvl, cs_fall, mosi_rise, mosi_fall};

    spi_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic                    miso_q, miso_d;
    logic                    tog_q, tog_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic                    mem_we;
    logic                    cs_hi;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // A cs rise pulse beats any sclk edge seen in the same cycle.
    assign cs_hi = cs_lvl | cs_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            miso_q  <= 1'b0;
            tog_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            miso_q  <= miso_d;
            tog_q   <= tog_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= shift_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        miso_d  = miso_q;
        tog_d   = tog_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mem_we  = 1'b0;

        if (cs_hi) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_d = {addr_q[ADDR_W-2:0], mosi_s};
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_RW;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_RW: begin
                    if (sclk_rise) begin
                        rd_d    = (mosi_s == RW_READ);
                        wr_d    = (mosi_s == RW_WRITE);
                        state_d = (mosi_s == RW_WRITE) ? ST_WR_DATA : ST_RD_LOAD;
                    end
                end
                ST_WR_DATA: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[DATA_W-2:0], mosi_s};
                        if (cnt_q == DATA_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_WR_COMMIT;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_WR_COMMIT: begin
                    mem_we = 1'b1;
                    tog_d  = ~tog_q;
`ifdef SPI_MEM_BURST_EN
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_WR_DATA;
`else
                    state_d = ST_HOLD;
`endif
                end
                ST_RD_LOAD: begin
                    shift_d = mem[addr_q];
`ifdef SPI_MEM_BURST_EN
                    addr_d  = addr_q + 1'b1;
`endif
                    state_d = ST_RD_SHIFT;
                end
                ST_RD_SHIFT: begin
                    if (sclk_fall) begin
                        miso_d  = shift_q[DATA_W-1];
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        if (cnt_q == DATA_LAST) begin
                            cnt_d = '0;
`ifdef SPI_MEM_BURST_EN
                            state_d = ST_RD_LOAD;
`else
                            state_d = ST_HOLD;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // The last read bit stays valid until the master's next fall.
                    if (sclk_fall) begin
                        miso_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign miso_pin = miso_q;
    assign leds     = {rd_q, wr_q, (state_q != ST_IDLE), tog_q};

endmodule

// File: tb/tb_spi_memory_burst.sv
// Scoreboard bench for spi_memory_burst: an 7x8 instance and a 4x16 instance.
module tb_spi_memory_burst;

    localparam int H = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sclk_v = 2'b00;
    logic [1:0] cs_v   = 2'b11;
    logic [1:0] mosi_v = 2'b00;
    logic [1:0] miso_v;
    logic [3:0] leds_a, leds_b;

    always #5 clk = ~clk;

    spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .sclk_pin(sclk_v[0]), .cs_pin(cs_v[0]),
        .mosi_pin(mosi_v[0]), .miso_pin(miso_v[0]), .leds(leds_a)
    );

    spi_memory_burst #(.ADDR_W(4), .DATA_W(16), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .reset(reset), .sclk_pin(sclk_v[1]), .cs_pin(cs_v[1]),
        .mosi_pin(mosi_v[1]), .miso_pin(miso_v[1]), .leds(leds_b)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;

    sb_t         exp_q[$];
    logic [31:0] got_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mon_g;
    sb_t         mon_e;
    logic        tog_a = 1'b0;

    task automatic expect_val(input string name, input logic [31:0] v);
        sb_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] v);
        got_q.push_back(v);
    endtask

    always @(negedge clk) begin
        while (got_q.size() > 0) begin
            mon_g = got_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output got %0h required none", mon_g);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_g !== mon_e.val) begin
                    n_fail++;
                    $display("FAIL %s got %0h required %0h", mon_e.name, mon_g, mon_e.val);
                end
            end
        end
    end

    task automatic frame(input int d, input logic [63:0] tx, input int n,
                         input bit end_cs, output logic [63:0] rx);
        rx = '0;
        @(negedge clk);
        cs_v[d] = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            mosi_v[d] = tx[i];
            repeat (H) @(negedge clk);
            sclk_v[d] = 1'b1;
            rx = {rx[62:0], miso_v[d]};
            repeat (H) @(negedge clk);
            sclk_v[d] = 1'b0;
        end
        if (end_cs) begin
            repeat (H) @(negedge clk);
            cs_v[d]   = 1'b1;
            mosi_v[d] = 1'b0;
            repeat (2 * H) @(negedge clk);
        end
    endtask

    task automatic spi_write(input int d, input int aw, input int dw, input logic [31:0] addr,
                             input logic [63:0] data, input int words);
        logic [63:0] tx, rx;
        tx = (64'(addr) << (dw * words + 1)) | data;
        frame(d, tx, aw + 1 + dw * words, 1'b1, rx);
    endtask

    task automatic spi_read(input int d, input int aw, input int dw, input logic [31:0] addr,
                            input int words, output logic [31:0] data);
        logic [63:0] tx, rx, mask;
        tx   = (64'(addr) << (dw * words + 1)) | (64'd1 << (dw * words));
        mask = (64'd1 << (dw * words)) - 64'd1;
        frame(d, tx, aw + 1 + dw * words, 1'b1, rx);
        data = 32'(rx & mask);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [63:0] rx;

        repeat (4) @(negedge clk);
        expect_val("reset_leds_a", 32'h0);  observe(32'(leds_a));
        expect_val("reset_miso_a", 32'h0);  observe(32'(miso_v[0]));
        expect_val("reset_leds_b", 32'h0);  observe(32'(leds_b));
        expect_val("reset_miso_b", 32'h0);  observe(32'(miso_v[1]));
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // single write then read back
        spi_write(0, 7, 8, 32'h2C, 64'hA5, 1);
        tog_a = ~tog_a;
        expect_val("leds_after_write", {28'h0, 3'b000, tog_a});
        observe(32'(leds_a));
        expect_val("read_2c", 32'hA5);
        spi_read(0, 7, 8, 32'h2C, 1, rd);
        observe(rd);

        // aborted write leaves the stored word alone
        spi_write(0, 7, 8, 32'h10, 64'hFF, 1);
        tog_a = ~tog_a;
        frame(0, {51'h0, 7'h10, 1'b0, 5'b00000}, 13, 1'b1, rx);
        expect_val("leds_after_abort", {28'h0, 3'b000, tog_a});
        observe(32'(leds_a));
        expect_val("read_10_after_abort", 32'hFF);
        spi_read(0, 7, 8, 32'h10, 1, rd);
        observe(rd);

`ifdef SPI_MEM_BURST_EN
        // three-word burst across the top of the address space
        spi_write(0, 7, 8, 32'h7E, 64'h112233, 3);
        tog_a = tog_a ^ 1'b1 ^ 1'b1 ^ 1'b1;
        expect_val("leds_after_burst", {28'h0, 3'b000, tog_a});
        observe(32'(leds_a));
        expect_val("burst_read_7e", 32'h112233);
        spi_read(0, 7, 8, 32'h7E, 3, rd);
        observe(rd);
        expect_val("read_00_wrapped", 32'h33);
        spi_read(0, 7, 8, 32'h00, 1, rd);
        observe(rd);
`else
        // a second word in the same frame is ignored
        spi_write(0, 7, 8, 32'h05, 64'h3C, 1);
        tog_a = ~tog_a;
        expect_val("read_05_16bits", 32'h3C00);
        spi_read(0, 7, 8, 32'h05, 2, rd);
        observe(rd);
        spi_write(0, 7, 8, 32'h07, 64'h99, 1);
        tog_a = ~tog_a;
        spi_write(0, 7, 8, 32'h06, 64'h7788, 2);
        tog_a = ~tog_a;
        expect_val("leds_after_hold_write", {28'h0, 3'b000, tog_a});
        observe(32'(leds_a));
        expect_val("read_06", 32'h77);
        spi_read(0, 7, 8, 32'h06, 1, rd);
        observe(rd);
        expect_val("read_07_untouched", 32'h99);
        spi_read(0, 7, 8, 32'h07, 1, rd);
        observe(rd);
`endif

        // reset in the middle of a read
        spi_write(0, 7, 8, 32'h33, 64'h5A, 1);
        tog_a = ~tog_a;
        frame(0, {53'h0, 7'h33, 1'b1, 3'b000}, 11, 1'b0, rx);
        repeat (6) @(negedge clk);
        expect_val("miso_mid_read", 32'h1);
        observe(32'(miso_v[0]));
        expect_val("leds_mid_read", {28'h0, 3'b101, tog_a});
        observe(32'(leds_a));
        reset = 1'b1;
        #1;
        expect_val("miso_on_reset", 32'h0);
        observe(32'(miso_v[0]));
        expect_val("leds_on_reset", 32'h0);
        observe(32'(leds_a));
        tog_a = 1'b0;
        cs_v[0]   = 1'b1;
        mosi_v[0] = 1'b0;
        sclk_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        expect_val("read_33_after_reset", 32'h5A);
        spi_read(0, 7, 8, 32'h33, 1, rd);
        observe(rd);
        expect_val("read_2c_after_reset", 32'hA5);
        spi_read(0, 7, 8, 32'h2C, 1, rd);
        observe(rd);

        // wide-data, narrow-address instance at its last address
        spi_write(1, 4, 16, 32'hF, 64'hBEEF, 1);
        expect_val("leds_b_after_write", 32'h1);
        observe(32'(leds_b));
        expect_val("read_b_f", 32'hBEEF);
        spi_read(1, 4, 16, 32'hF, 1, rd);
        observe(rd);

        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
